// File: rtl/usb_pkg.sv
// Shared definitions for the reconfigurable switch box: side indices,
// select codes, configuration FSM states and the per-output select helper.
package usb_pkg;

    localparam int CFG_BITS_PER_TRACK = 8;

    // Side indices; also the 2-bit field slot inside a track's config byte
    localparam int SIDE_N = 0;
    localparam int SIDE_E = 1;
    localparam int SIDE_S = 2;
    localparam int SIDE_W = 3;

    // Select codes: CWn picks the side n steps clockwise from the output side
    localparam logic [1:0] SEL_OFF = 2'b00;
    localparam logic [1:0] SEL_CW1 = 2'b01;
    localparam logic [1:0] SEL_CW2 = 2'b10;
    localparam logic [1:0] SEL_CW3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_t;

    // Resolve one output from its select code and its three candidate inputs,
    // which the caller passes already in clockwise order from the output side.
    function automatic logic route_pick(
        input logic [1:0] sel,
        input logic       cw1,
        input logic       cw2,
        input logic       cw3
    );
        logic result;
        case (sel)
            SEL_CW1: result = cw1;
            SEL_CW2: result = cw2;
            SEL_CW3: result = cw3;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/usb_track_mux.sv
// Combinational routing for a single track index: four side inputs, one
// config byte (2 bits per output side), four side outputs.
module usb_track_mux
    import usb_pkg::*;
(
    input  logic [3:0] side_in,
    input  logic [7:0] cfg,
    output logic [3:0] side_out
);

    // Clockwise candidate order per output side: N:E,S,W  E:S,W,N  S:W,N,E  W:N,E,S
    assign side_out[SIDE_N] = route_pick(cfg[2*SIDE_N+1 : 2*SIDE_N],
                                         side_in[SIDE_E], side_in[SIDE_S], side_in[SIDE_W]);
    assign side_out[SIDE_E] = route_pick(cfg[2*SIDE_E+1 : 2*SIDE_E],
                                         side_in[SIDE_S], side_in[SIDE_W], side_in[SIDE_N]);
    assign side_out[SIDE_S] = route_pick(cfg[2*SIDE_S+1 : 2*SIDE_S],
                                         side_in[SIDE_W], side_in[SIDE_N], side_in[SIDE_E]);
    assign side_out[SIDE_W] = route_pick(cfg[2*SIDE_W+1 : 2*SIDE_W],
                                         side_in[SIDE_N], side_in[SIDE_E], side_in[SIDE_S]);

endmodule

// File: rtl/universal_switch_box_rcfg.sv
// Runtime-reconfigurable unidirectional switch box. Configuration arrives
// serially into a shadow register and is committed to the active register
// in one cycle, so routing never sees a half-loaded configuration.
module universal_switch_box_rcfg
    import usb_pkg::*;
#(
    parameter int W       = 8,
    parameter bit REG_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] north_in,
    input  logic [W-1:0] east_in,
    input  logic [W-1:0] south_in,
    input  logic [W-1:0] west_in,
    output logic [W-1:0] north_out,
    output logic [W-1:0] east_out,
    output logic [W-1:0] south_out,
    output logic [W-1:0] west_out,
    input  logic         cfg_start,
    input  logic         cfg_bit,
    input  logic         cfg_bit_valid,
    output logic         cfg_scan_out,
    output logic         cfg_busy,
    output logic         cfg_done
);

    localparam int CW    = CFG_BITS_PER_TRACK * W;
    localparam int CNT_W = $clog2(CW + 1);

    cfg_state_t      state;
    logic [CW-1:0]   shadow;
    logic [CW-1:0]   active;
    logic [CNT_W-1:0] counter;

    logic [W-1:0] route_n;
    logic [W-1:0] route_e;
    logic [W-1:0] route_s;
    logic [W-1:0] route_w;

    // Load sequencer: shifts serial bits into the shadow and commits them atomically
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            shadow       <= '0;
            active       <= '0;
            counter      <= '0;
            cfg_scan_out <= 1'b0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cfg_done <= 1'b0;
                    if (cfg_start) begin
                        state    <= ST_SHIFT;
                        counter  <= '0;
                        cfg_busy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cfg_bit_valid) begin
                        shadow       <= {cfg_bit, shadow[CW-1:1]};
                        cfg_scan_out <= shadow[0];
                        counter      <= counter + 1'b1;
                        if (counter == CNT_W'(CW - 1)) begin
                            state    <= ST_COMMIT;
                            cfg_done <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    active   <= shadow;
                    cfg_done <= 1'b0;
                    cfg_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    cfg_busy <= 1'b0;
                    cfg_done <= 1'b0;
                end
            endcase
        end
    end

    // One routing mux per track index, each fed by its own config byte
    for (genvar t = 0; t < W; t++) begin : g_track
        logic [3:0] track_in;
        logic [3:0] track_out;

        assign track_in[SIDE_N] = north_in[t];
        assign track_in[SIDE_E] = east_in[t];
        assign track_in[SIDE_S] = south_in[t];
        assign track_in[SIDE_W] = west_in[t];

        usb_track_mux u_mux (
            .side_in  (track_in),
            .cfg      (active[CFG_BITS_PER_TRACK*t +: CFG_BITS_PER_TRACK]),
            .side_out (track_out)
        );

        assign route_n[t] = track_out[SIDE_N];
        assign route_e[t] = track_out[SIDE_E];
        assign route_s[t] = track_out[SIDE_S];
        assign route_w[t] = track_out[SIDE_W];
    end

    if (REG_OUT) begin : g_reg_out
        // Pipeline stage for registered fabric channels
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                north_out <= '0;
                east_out  <= '0;
                south_out <= '0;
                west_out  <= '0;
            end else begin
                north_out <= route_n;
                east_out  <= route_e;
                south_out <= route_s;
                west_out  <= route_w;
            end
        end
    end else begin : g_comb_out
        assign north_out = route_n;
        assign east_out  = route_e;
        assign south_out = route_s;
        assign west_out  = route_w;
    end

endmodule

// File: tb/tb_universal_switch_box_rcfg.sv
// Bench for universal_switch_box_rcfg: one combinational and one registered
// instance share all stimulus and are checked every cycle against a model.
module tb_universal_switch_box_rcfg;

    localparam int W  = 4;
    localparam int CW = 8 * W;

    localparam logic [CW-1:0] CFG_A = {4{8'b10101111}};   // N<-W, E<-N, S<-N, W<-E
    localparam logic [CW-1:0] CFG_B = {4{8'b00000010}};   // N<-S only

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] north_in, east_in, south_in, west_in;
    logic         cfg_start, cfg_bit, cfg_bit_valid;

    logic [W-1:0] n0, e0, s0, w0, n1, e1, s1, w1;
    logic         scan0, busy0, done0, scan1, busy1, done1;

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int busy_count = 0;

    // Model state
    logic [CW-1:0]  m_active = '0;
    logic [CW-1:0]  m_shadow = '0;
    logic [4*W-1:0] m_reg    = '0;
    logic           m_scan   = 1'b0;
    logic           m_loading = 1'b0;
    logic           m_commit  = 1'b0;
    int             m_cnt     = 0;

    universal_switch_box_rcfg #(.W(W), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .north_out(n0), .east_out(e0), .south_out(s0), .west_out(w0),
        .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_bit_valid(cfg_bit_valid),
        .cfg_scan_out(scan0), .cfg_busy(busy0), .cfg_done(done0)
    );

    universal_switch_box_rcfg #(.W(W), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .north_out(n1), .east_out(e1), .south_out(s1), .west_out(w1),
        .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_bit_valid(cfg_bit_valid),
        .cfg_scan_out(scan1), .cfg_busy(busy1), .cfg_done(done1)
    );

    always #5 clk = ~clk;

    // Output side s, code c (nonzero) takes the input of side (s+c) mod 4
    function automatic logic [4*W-1:0] route(input logic [CW-1:0] cfg, input logic [4*W-1:0] ins);
        logic [4*W-1:0] r;
        int code;
        r = '0;
        for (int t = 0; t < W; t++) begin
            for (int s = 0; s < 4; s++) begin
                code = int'(cfg[8*t + 2*s +: 2]);
                if (code != 0) r[s*W + t] = ins[((s + code) % 4)*W + t];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] e,
                                 input logic [W-1:0] s, input logic [W-1:0] w);
        north_in = n;
        east_in  = e;
        south_in = s;
        west_in  = w;
    endtask

    // Serial load, first bit = bit 0; gap inserts idle cycles between bits,
    // poke_at pulses cfg_start alongside that bit index (negative = never).
    // Returns what cfg_scan_out presented after each valid bit.
    task automatic loadConfig(input logic [CW-1:0] word, input int gap, input int poke_at,
                              output logic [CW-1:0] scanned);
        scanned = '0;
        @(posedge clk); #1;
        busy_count = 0;
        done_count = 0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < CW; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = word[i];
            cfg_start     = (i == poke_at);
            @(posedge clk); #1;
            scanned[i]    = scan0;
            cfg_start     = 1'b0;
            cfg_bit_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        cfg_bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Abstract model: collects valid bits after a start, commits after CW of them
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= '0;
            m_shadow  <= '0;
            m_reg     <= '0;
            m_scan    <= 1'b0;
            m_loading <= 1'b0;
            m_commit  <= 1'b0;
            m_cnt     <= 0;
        end else begin
            m_reg <= route(m_active, {west_in, south_in, east_in, north_in});
            if (m_commit) begin
                m_active <= m_shadow;
                m_commit <= 1'b0;
            end else if (m_loading) begin
                if (cfg_bit_valid) begin
                    m_scan   <= m_shadow[0];
                    m_shadow <= {cfg_bit, m_shadow[CW-1:1]};
                    m_cnt    <= m_cnt + 1;
                    if (m_cnt + 1 == CW) begin
                        m_loading <= 1'b0;
                        m_commit  <= 1'b1;
                    end
                end
            end else if (cfg_start) begin
                m_loading <= 1'b1;
                m_cnt     <= 0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        logic [4*W-1:0] exp_comb;
        exp_comb = route(m_active, {west_in, south_in, east_in, north_in});
        checkOutput("comb_outputs", 32'({w0, s0, e0, n0}), 32'(exp_comb));
        checkOutput("reg_outputs",  32'({w1, s1, e1, n1}), 32'(m_reg));
        checkOutput("busy", 32'({busy1, busy0}), 32'({2{m_loading | m_commit}}));
        checkOutput("done", 32'({done1, done0}), 32'({2{m_commit}}));
        checkOutput("scan", 32'({scan1, scan0}), 32'({2{m_scan}}));
        if (done0) done_count <= done_count + 1;
        if (busy0) busy_count <= busy_count + 1;
    end

    initial begin
        logic [CW-1:0] scanned;

        // Reset state with all inputs high
        rst = 1'b1;
        cfg_start = 1'b0; cfg_bit = 1'b0; cfg_bit_valid = 1'b0;
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF);
        #2;
        checkOutput("reset_outputs_comb", 32'({w0, s0, e0, n0}), 32'h0);
        checkOutput("reset_outputs_reg",  32'({w1, s1, e1, n1}), 32'h0);
        checkOutput("reset_busy_done", 32'({busy0, done0}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_outputs_comb", 32'({w0, s0, e0, n0}), 32'h0);
        checkOutput("idle_outputs_reg",  32'({w1, s1, e1, n1}), 32'h0);

        // Continuous load of CFG_A
        loadConfig(CFG_A, 0, -1, scanned);
        checkOutput("load_a_done_pulses", 32'(done_count), 32'd1);
        checkOutput("load_a_busy_cycles", 32'(busy_count), 32'd33);
        checkOutput("load_a_scan_prev", 32'(scanned), 32'h0);
        applyStimulus(4'h5, 4'hC, 4'h3, 4'hA);
        #1;
        checkOutput("route_a_north", 32'(n0), 32'hA);
        checkOutput("route_a_east",  32'(e0), 32'h5);
        checkOutput("route_a_south", 32'(s0), 32'h5);
        checkOutput("route_a_west",  32'(w0), 32'hC);
        @(posedge clk); #1;
        checkOutput("route_a_reg", 32'({w1, s1, e1, n1}), 32'hC55A);

        // Gapped load of CFG_B; shadow previously held CFG_A
        loadConfig(CFG_B, 1, -1, scanned);
        checkOutput("load_b_done_pulses", 32'(done_count), 32'd1);
        checkOutput("load_b_busy_cycles", 32'(busy_count), 32'd64);
        checkOutput("load_b_scan_prev", 32'(scanned), 32'(CFG_A));

        // Registered latency with N<-S
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 applyStimulus(4'h0, 4'h0, 4'h3, 4'h0);
        #1;
        checkOutput("lat_comb_north", 32'(n0), 32'h3);
        checkOutput("lat_reg_before", 32'(n1), 32'h0);
        @(posedge clk); #1;
        checkOutput("lat_reg_after", 32'(n1), 32'h3);

        // Valid bits while idle, then a start pulse mid-load: both ignored
        for (int i = 0; i < 4; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit = i[0];
            @(posedge clk); #1;
        end
        cfg_bit_valid = 1'b0;
        checkOutput("idle_valid_busy", 32'(busy0), 32'h0);
        loadConfig(CFG_A, 0, 5, scanned);
        checkOutput("poke_done_pulses", 32'(done_count), 32'd1);
        checkOutput("poke_busy_cycles", 32'(busy_count), 32'd33);
        checkOutput("poke_scan_prev", 32'(scanned), 32'(CFG_B));
        applyStimulus(4'h5, 4'hC, 4'h3, 4'hA);
        #1;
        checkOutput("route_poke", 32'({w0, s0, e0, n0}), 32'hC55A);

        // Reset after 10 bits of a load abandons it
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit = CFG_B[i];
            @(posedge clk); #1;
        end
        cfg_bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs_comb", 32'({w0, s0, e0, n0}), 32'h0);
        checkOutput("abort_outputs_reg",  32'({w1, s1, e1, n1}), 32'h0);
        checkOutput("abort_busy", 32'(busy0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        loadConfig(CFG_A, 0, -1, scanned);
        checkOutput("reload_done_pulses", 32'(done_count), 32'd1);
        checkOutput("reload_scan_prev", 32'(scanned), 32'h0);
        #1;
        checkOutput("route_reload", 32'({w0, s0, e0, n0}), 32'hC55A);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
